// File: rtl/mod96_pkg.sv
// mod96_pkg
// Shared constants and types for the 96-bit to 64-bit modular reducer.
//   D_WIDTH        : width of the unreduced operand A
//   P_WIDTH        : width of the modulus and of the reduced result
//   MOD_GOLDILOCKS : target modulus N = 2^64 - 2^32 + 1
//   t1_t           : 65-bit stage-1 partial sum (carry + 64 bits)
//   t2_t           : 66-bit stage-2 value t1 - d
package mod96_pkg;

  localparam int D_WIDTH = 96;
  localparam int P_WIDTH = 64;

  localparam logic [63:0] MOD_GOLDILOCKS = 64'hFFFFFFFF_00000001;

  typedef logic [64:0] t1_t;
  typedef logic [65:0] t2_t;

endpackage

// File: rtl/mod96_cond_sub.sv
// mod96_cond_sub
// Combinational final correction: picks t2, t2 - N or t2 - 2N, whichever is
// the largest non-negative candidate, and returns its low 64 bits.
// Ports:
//   t2    in  66  value to reduce, t2 < 2^65 < 3N
//   ninv2 in  65  ~{1'b0, N}
//   res   out 64  t2 mod N
module mod96_cond_sub
  import mod96_pkg::*;
(
  input  t2_t         t2,
  input  logic [64:0] ninv2,
  output logic [63:0] res
);

  logic [66:0] u1;
  logic [66:0] u2;
  logic        unused_high_bits;

  // 67-bit two's complement: {2'b11, ~N} + 1 is -N, and {1'b1, ~N, 1'b1} + 1
  // is ~(2N) + 1 = -2N, so bit 66 is the sign of each difference.
  assign u1 = {1'b0, t2} + {2'b11, ninv2} + 67'd1;
  assign u2 = {1'b0, t2} + {1'b1, ninv2, 1'b1} + 67'd1;

  // Bits 65:64 of the differences are zero whenever a candidate is selected.
  assign unused_high_bits = ^{u1[65:64], u2[65:64]};

  always_comb begin
    res = t2[63:0];
    if (!u2[66]) begin
      res = u2[63:0];
    end else if (!u1[66]) begin
      res = u1[63:0];
    end
  end

endmodule

// File: rtl/mod96_reduce_pipe.sv
// mod96_reduce_pipe
// Three-stage pipelined reduction of a 96-bit value A = d*2^64 + ef modulo N,
// using 2^64 == 2^32 - 1 (mod N), i.e. A == ef + d*2^32 - d.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   in_valid/in_ready  operand handshake into stage 1
//   efD_in             low 64 bits of A (2^32*e + f)
//   dHD_in             d shifted up by 32
//   dLDinv_in          ~{32'h0, d}
//   Ninv2_in           ~{1'b0, N}
//   t1_s_out/t1_c_out  stage-1 partial sum, sent to the preprocessing stage
//   t1D_in             {t1_c_out, t1_s_out} returned by the preprocessing stage
//   out_valid/out_ready result handshake out of stage 3
//   res_out            A mod N
module mod96_reduce_pipe
  import mod96_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] efD_in,
  input  logic [63:0] dHD_in,
  input  logic [63:0] dLDinv_in,
  input  logic [64:0] Ninv2_in,
  output logic [63:0] t1_s_out,
  output logic        t1_c_out,
  input  t1_t         t1D_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] res_out
);

  logic        v1;
  logic        v2;
  logic        v3;
  logic        ready1;
  logic        ready2;
  logic        ready3;

  logic [63:0] dldinv_1;
  logic [64:0] ninv2_1;
  t2_t         t2_2;
  logic [64:0] ninv2_2;

  t1_t         t1_next;
  t2_t         t2_next;
  logic [63:0] res_next;

  // A stage can take new data when it is empty or its content moves on.
  assign ready3   = ~v3 | out_ready;
  assign ready2   = ~v2 | ready3;
  assign ready1   = ~v1 | ready2;
  assign in_ready = ready1;

  assign out_valid = v3;

  // ef + d*2^32 fits in 65 bits, so the carry captures the full sum.
  assign t1_next = {1'b0, efD_in} + {1'b0, dHD_in};

  // {2'b11, ~{32'h0, d}} + 1 is -d in 66 bits; t1 >= d*2^32 >= d keeps t2 >= 0.
  assign t2_next = {1'b0, t1D_in} + {2'b11, dldinv_1} + 66'd1;

  mod96_cond_sub u_cond_sub (
    .t2    (t2_2),
    .ninv2 (ninv2_2),
    .res   (res_next)
  );

  // Each stage captures only when it advances and its source holds a valid
  // item, so stalled stages keep their contents bit-exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1       <= 1'b0;
      v2       <= 1'b0;
      v3       <= 1'b0;
      t1_s_out <= '0;
      t1_c_out <= 1'b0;
      dldinv_1 <= '0;
      ninv2_1  <= '0;
      t2_2     <= '0;
      ninv2_2  <= '0;
      res_out  <= '0;
    end else begin
      if (ready1) begin
        v1 <= in_valid;
        if (in_valid) begin
          {t1_c_out, t1_s_out} <= t1_next;
          dldinv_1             <= dLDinv_in;
          ninv2_1              <= Ninv2_in;
        end
      end
      if (ready2) begin
        v2 <= v1;
        if (v1) begin
          t2_2    <= t2_next;
          ninv2_2 <= ninv2_1;
        end
      end
      if (ready3) begin
        v3 <= v2;
        if (v2) begin
          res_out <= res_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_mod96_reduce_pipe.sv
// tb_mod96_reduce_pipe
// Scoreboard bench: the driver pushes A mod N (plain 96-bit arithmetic) for
// every accepted operand; an independent monitor pops and compares whenever
// a result transfers, and also checks that a stalled output holds steady.
module tb_mod96_reduce_pipe;
  import mod96_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] efD_in = '0;
  logic [63:0] dHD_in = '0;
  logic [63:0] dLDinv_in = '0;
  logic [64:0] Ninv2_in = '0;
  logic [63:0] t1_s_out;
  logic        t1_c_out;
  logic [64:0] t1D_in;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] res_out;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          rand_ready = 1'b0;
  bit          hold_pending = 1'b0;
  logic [63:0] held_res = '0;

  // The preprocessing stage returns the stage-1 sum combinationally.
  assign t1D_in = {t1_c_out, t1_s_out};

  mod96_reduce_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .efD_in    (efD_in),
    .dHD_in    (dHD_in),
    .dLDinv_in (dLDinv_in),
    .Ninv2_in  (Ninv2_in),
    .t1_s_out  (t1_s_out),
    .t1_c_out  (t1_c_out),
    .t1D_in    (t1D_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res_out   (res_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  function automatic logic [63:0] ref_mod(input logic [95:0] a);
    logic [95:0] m;
    m = a % {32'h0, MOD_GOLDILOCKS};
    return m[63:0];
  endfunction

  function automatic logic [95:0] rand_a();
    return {$urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Splits A into the operand set the preprocessing stage would produce.
  task automatic drive_operands(input logic [95:0] a);
    efD_in    = a[63:0];
    dHD_in    = {a[95:64], 32'h0};
    dLDinv_in = ~{32'h0, a[95:64]};
    Ninv2_in  = ~{1'b0, MOD_GOLDILOCKS};
  endtask

  task automatic applyStimulus(input logic [95:0] a, input logic [63:0] exp, input bit lat,
                               input bit must_ready);
    int   waited;
    exp_t e;
    drive_operands(a);
    in_valid = 1'b1;
    waited = 0;
    while (1) begin
      @(negedge clk);
      if (must_ready && waited == 0) checkOutput("in_ready_stream", 64'(in_ready), 64'd1);
      if (in_ready) begin
        e.res = exp;
        e.cyc = cyc;
        e.lat = lat;
        sb.push_back(e);
        break;
      end
      waited++;
      if (waited > 50) begin
        checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drop_valid();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops on every output transfer and checks stalled outputs hold.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        checkOutput("hold_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_value", res_out, held_res);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("extra_output", 64'(out_valid), 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("result", res_out, e.res);
          if (e.lat) checkOutput("latency", 64'(cyc - e.cyc), 64'd3);
        end
      end
      hold_pending = out_valid && !out_ready;
      held_res     = res_out;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [95:0] a;
    int          acc;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd1);
    checkOutput("reset_t1_s", t1_s_out, 64'd0);
    checkOutput("reset_t1_c", 64'(t1_c_out), 64'd0);
    checkOutput("reset_res", res_out, 64'd0);
    @(posedge clk);
    #1;

    // Directed boundary values with independent constant expectations.
    applyStimulus(96'h0, 64'h0, 1'b1, 1'b0);
    drop_valid();
    wait_drain();
    applyStimulus({32'h0, MOD_GOLDILOCKS}, 64'h0, 1'b1, 1'b0);
    applyStimulus(96'h1_00000000_00000000, 64'h00000000_FFFFFFFF, 1'b1, 1'b0);
    drop_valid();
    wait_drain();
    applyStimulus({96{1'b1}}, 64'hFFFFFFFE_FFFFFFFF, 1'b1, 1'b0);
    drop_valid();
    checkOutput("t1_c_max", 64'(t1_c_out), 64'd1);
    checkOutput("t1_s_max", t1_s_out, 64'hFFFFFFFE_FFFFFFFF);
    wait_drain();

    // Back-to-back random stream, never stalled.
    for (int i = 0; i < 8; i++) begin
      a = rand_a();
      applyStimulus(a, ref_mod(a), 1'b1, 1'b1);
    end
    drop_valid();
    wait_drain();

    // Output stalled for six cycles while the source keeps offering data.
    out_ready = 1'b0;
    acc = 0;
    a = rand_a();
    drive_operands(a);
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 3) checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
      if (in_ready) begin
        sb.push_back('{res: ref_mod(a), cyc: cyc, lat: 1'b0});
        acc++;
        @(posedge clk);
        #1;
        a = rand_a();
        drive_operands(a);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    checkOutput("stall_accept_count", 64'(acc), 64'd3);
    out_ready = 1'b1;
    applyStimulus(a, ref_mod(a), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      a = rand_a();
      applyStimulus(a, ref_mod(a), 1'b0, 1'b0);
    end
    drop_valid();
    wait_drain();

    // Random backpressure.
    rand_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      a = rand_a();
      applyStimulus(a, ref_mod(a), 1'b0, 1'b0);
    end
    drop_valid();
    wait_drain();
    rand_ready = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset with three items in flight: none of them may emerge.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a = rand_a();
      applyStimulus(a, ref_mod(a), 1'b0, 1'b0);
    end
    drop_valid();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    checkOutput("flush_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("flush_no_stale", 64'(out_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    a = rand_a();
    applyStimulus(a, ref_mod(a), 1'b1, 1'b0);
    drop_valid();
    wait_drain();

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
